// File: rtl/msg_generator_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if : 64-bit Avalon-ST streaming link.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready.
// Once the source raises valid it holds data/startofpacket/endofpacket/empty
// stable and keeps valid high until the beat is accepted. The source never
// derives valid from ready.
//
// Signals:
//   data[63:0]     beat payload, first byte on data[63:56]
//   valid          source has a beat on the bus
//   ready          sink can accept a beat this cycle
//   startofpacket  first beat of a message
//   endofpacket    last beat of a message
//   empty[2:0]     unused low-order bytes on the endofpacket beat
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface avalon_st_if;
    logic [63:0] data;
    logic        valid;
    logic        ready;
    logic        startofpacket;
    logic        endofpacket;
    logic [2:0]  empty;

    modport master (
        output data, valid, startofpacket, endofpacket, empty,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket, empty,
        output ready
    );
endinterface

// File: rtl/msg_generator.sv
// -----------------------------------------------------------------------------
// msg_generator : replays a fixed message (MSG_DATA, MSG_BYTES long) on an
// Avalon-ST source port, either a programmed number of times or continuously,
// with GAP_CYCLES idle cycles between messages. Sink backpressure is honoured
// and a message in flight is always completed (except by reset).
//
// Optional feature macro: MSG_GENERATOR_SEQ_EN
//   defined   : the last two message bytes carry msg_cnt (big-endian) of the
//               message being sent; requires MSG_BYTES >= 2.
//   undefined : MSG_DATA is sent unmodified.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       pulse, begins a run when idle (count latched here)
//   stop        pulse, ends the run after the message in flight
//   count[15:0] messages per run, 0 = continuous
//   msg_out     avalon_st_if.master message stream
//   busy        high while a run is active
//   msg_cnt     messages fully accepted in the current run (saturating)
//   done        one-cycle pulse when a run ends
//   fsm_state   current FSM state (0 IDLE, 1 SEND, 2 GAP, 3 DONE) for debug
// -----------------------------------------------------------------------------
module msg_generator #(
    parameter int MSG_BYTES = 44,
    parameter logic [MSG_BYTES*8-1:0] MSG_DATA =
        352'h0000001c24174acb00e04c68004108004500001c4bfd000080110000a9fe96dfa9fe0101c17507d00008ebf6,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] count,
    avalon_st_if.master msg_out,
    output logic        busy,
    output logic [15:0] msg_cnt,
    output logic        done,
    output logic [1:0]  fsm_state
);
    localparam int BEATS      = (MSG_BYTES + 7) / 8;
    localparam int PAD_W      = BEATS * 64;
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [BEAT_W-1:0] LAST_IDX   = BEAT_W'(BEATS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_LAST_I);
    localparam logic [2:0]        LAST_EMPTY = 3'(BEATS * 8 - MSG_BYTES);
    localparam logic [2:0]        FIRST_EMPTY = (BEATS == 1) ? LAST_EMPTY : 3'd0;
    localparam logic              FIRST_EOP   = (BEATS == 1);

    // Message left-aligned in whole beats; trailing pad bytes are zero.
    localparam logic [PAD_W-1:0] MSG_PADDED =
        PAD_W'(MSG_DATA) << (PAD_W - MSG_BYTES * 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [15:0]       count_q;
    logic              stop_pending;
    logic              valid_q;
    logic              sop_q;
    logic              eop_q;
    logic [2:0]        empty_q;

    logic [PAD_W-1:0]  image;
    logic [BEAT_W-1:0] next_idx;
    logic [15:0]       cnt_inc;
    logic              run_complete;

    // The payload is looked up from the registered beat index (and msg_cnt
    // when sequence stamping is on), so it is stable for as long as valid is.
    // msg_cnt is constant for the whole message being sent.
    always_comb begin
        image = MSG_PADDED;
`ifdef MSG_GENERATOR_SEQ_EN
        image[PAD_W - 1 - 8 * (MSG_BYTES - 2) -: 16] = msg_cnt;
`endif
    end

    assign next_idx     = beat_idx + 1'b1;
    assign cnt_inc      = (msg_cnt == 16'hFFFF) ? msg_cnt : msg_cnt + 16'd1;
    assign run_complete = (count_q != 16'd0) &&
                          (({1'b0, msg_cnt} + 17'd1) == {1'b0, count_q});

    assign msg_out.valid         = valid_q;
    assign msg_out.startofpacket = sop_q;
    assign msg_out.endofpacket   = eop_q;
    assign msg_out.empty         = empty_q;
    assign msg_out.data          = valid_q ? image[PAD_W - 1 - 64 * int'(beat_idx) -: 64]
                                           : 64'd0;
    assign fsm_state             = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            beat_idx     <= '0;
            gap_cnt      <= '0;
            count_q      <= '0;
            stop_pending <= 1'b0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= '0;
            busy         <= 1'b0;
            msg_cnt      <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && stop) begin
                stop_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_SEND;
                        count_q      <= count;
                        msg_cnt      <= '0;
                        busy         <= 1'b1;
                        // start+stop together still yields exactly one message
                        stop_pending <= stop;
                        beat_idx     <= '0;
                        valid_q      <= 1'b1;
                        sop_q        <= 1'b1;
                        eop_q        <= FIRST_EOP;
                        empty_q      <= FIRST_EMPTY;
                    end
                end

                S_SEND: begin
                    if (valid_q && msg_out.ready) begin
                        if (eop_q) begin
                            msg_cnt <= cnt_inc;
                            if (stop_pending || stop || run_complete) begin
                                state        <= S_DONE;
                                valid_q      <= 1'b0;
                                sop_q        <= 1'b0;
                                eop_q        <= 1'b0;
                                empty_q      <= '0;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                                stop_pending <= 1'b0;
                            end else if (GAP_CYCLES > 0) begin
                                state   <= S_GAP;
                                gap_cnt <= '0;
                                valid_q <= 1'b0;
                                sop_q   <= 1'b0;
                                eop_q   <= 1'b0;
                                empty_q <= '0;
                            end else begin
                                // back-to-back: next beat is the next sop
                                beat_idx <= '0;
                                sop_q    <= 1'b1;
                                eop_q    <= FIRST_EOP;
                                empty_q  <= FIRST_EMPTY;
                            end
                        end else begin
                            beat_idx <= next_idx;
                            sop_q    <= 1'b0;
                            eop_q    <= (next_idx == LAST_IDX);
                            empty_q  <= (next_idx == LAST_IDX) ? LAST_EMPTY : 3'd0;
                        end
                    end
                end

                S_GAP: begin
                    if (stop || stop_pending) begin
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        stop_pending <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state    <= S_SEND;
                        beat_idx <= '0;
                        valid_q  <= 1'b1;
                        sop_q    <= 1'b1;
                        eop_q    <= FIRST_EOP;
                        empty_q  <= FIRST_EMPTY;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_msg_generator.sv
module tb_msg_generator;
    localparam int MSG_BYTES  = 44;
    localparam int GAP_CYCLES = 4;
    localparam int BEATS      = (MSG_BYTES + 7) / 8;
    localparam logic [MSG_BYTES*8-1:0] MSG_DATA =
        352'h0000001c24174acb00e04c68004108004500001c4bfd000080110000a9fe96dfa9fe0101c17507d00008ebf6;
`ifdef MSG_GENERATOR_SEQ_EN
    localparam logic [63:0] EXP_LAST0 = 64'h0008000000000000;
`else
    localparam logic [63:0] EXP_LAST0 = 64'h0008ebf600000000;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] count = 16'd0;
    logic        busy;
    logic [15:0] msg_cnt;
    logic        done;
    logic [1:0]  fsm_state;

    avalon_st_if msg_if ();

    msg_generator #(
        .MSG_BYTES (MSG_BYTES),
        .MSG_DATA  (MSG_DATA),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .count    (count),
        .msg_out  (msg_if),
        .busy     (busy),
        .msg_cnt  (msg_cnt),
        .done     (done),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] msg_byte(input int m, input int b);
        logic [MSG_BYTES*8-1:0] d;
`ifdef MSG_GENERATOR_SEQ_EN
        logic [15:0] s;
        s = 16'(m);
        if (b == MSG_BYTES - 2) return s[15:8];
        if (b == MSG_BYTES - 1) return s[7:0];
`endif
        d = MSG_DATA;
        return d[(MSG_BYTES - 1 - b) * 8 +: 8];
    endfunction

    function automatic logic [63:0] exp_beat(input int m, input int k);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r = {r[55:0], (8 * k + j < MSG_BYTES) ? msg_byte(m, 8 * k + j) : 8'h00};
        end
        return r;
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [63:0] exp_q[$];
    int          beat_pos = 0;
    int          msgs_in_run = 0;
    int          run_start_cyc = 0;
    bit          first_in_run = 1'b0;
    int          last_eop_cyc = 0;
    bit          cnt_chk_pending = 1'b0;
    int          done_seen = 0;
    int          valid_cycles = 0;
    logic [63:0] run_first_data = '0;
    logic [63:0] run_last_data = '0;
    logic [2:0]  run_last_empty = '0;
    bit          prev_valid = 1'b0;
    bit          prev_acc = 1'b0;
    logic [63:0] prev_data = '0;
    logic [4:0]  prev_flags = '0;
    bit          rand_ready = 1'b0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            exp_q.delete();
            beat_pos        = 0;
            prev_valid      = 1'b0;
            prev_acc        = 1'b0;
            cnt_chk_pending = 1'b0;
        end else begin
            if (cnt_chk_pending) begin
                check_val("msg_cnt_after_eop", msg_cnt, sat16(msgs_in_run));
                cnt_chk_pending = 1'b0;
            end
            if (prev_valid && !prev_acc) begin
                check_val("hold_valid", msg_if.valid, 1);
                check_val("hold_data", msg_if.data, prev_data);
                check_val("hold_flags", {msg_if.startofpacket, msg_if.endofpacket, msg_if.empty}, prev_flags);
            end
            if (msg_if.valid && !prev_valid) begin
                if (first_in_run) begin
                    check_val("start_latency", cyc - run_start_cyc, 1);
                    first_in_run = 1'b0;
                end else begin
                    check_val("gap_len", cyc - last_eop_cyc, 1 + GAP_CYCLES);
                end
            end
            if (msg_if.valid) valid_cycles++;
            if (msg_if.valid && msg_if.ready) begin
                if (beat_pos == 0) begin
                    for (int k = 0; k < BEATS; k++) exp_q.push_back(exp_beat(msgs_in_run, k));
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                check_val("beat_data", msg_if.data, e);
                check_val("beat_flags", {msg_if.startofpacket, msg_if.endofpacket, msg_if.empty},
                          {beat_pos == 0, beat_pos == BEATS - 1,
                           (beat_pos == BEATS - 1) ? 3'(BEATS * 8 - MSG_BYTES) : 3'd0});
                if (beat_pos == 0) run_first_data = msg_if.data;
                if (beat_pos == BEATS - 1) begin
                    run_last_data   = msg_if.data;
                    run_last_empty  = msg_if.empty;
                    beat_pos        = 0;
                    msgs_in_run++;
                    last_eop_cyc    = cyc;
                    cnt_chk_pending = 1'b1;
                end else begin
                    beat_pos++;
                end
            end
            if (done) begin
                done_seen++;
                check_val("done_timing", cyc - last_eop_cyc, 1);
                check_val("done_busy", busy, 0);
                check_val("done_msg_cnt", msg_cnt, sat16(msgs_in_run));
            end
            prev_valid = msg_if.valid;
            prev_acc   = msg_if.valid && msg_if.ready;
            prev_data  = msg_if.data;
            prev_flags = {msg_if.startofpacket, msg_if.endofpacket, msg_if.empty};
        end
    end

    // ---------------- drivers ----------------
    initial begin
        msg_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            msg_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_run(input logic [15:0] n, input bit with_stop);
        @(posedge clk);
        #2;
        count         = n;
        start         = 1'b1;
        stop          = with_stop;
        run_start_cyc = cyc;
        first_in_run  = 1'b1;
        msgs_in_run   = 0;
        beat_pos      = 0;
        exp_q.delete();
        @(posedge clk);
        #2;
        start = 1'b0;
        stop  = 1'b0;
        count = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        int t;
        base = done_seen;
        t = 0;
        while (done_seen == base && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_val(tag, done_seen != base, 1);
    endtask

    task automatic wait_pos(input string tag, input int m, input int p, input int budget);
        int t;
        t = 0;
        while ((msgs_in_run != m || beat_pos != p) && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_val(tag, (msgs_in_run == m) && (beat_pos == p), 1);
    endtask

    task automatic pulse_stop();
        @(posedge clk);
        #2;
        stop = 1'b1;
        @(posedge clk);
        #2;
        stop = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int vc;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", msg_if.valid, 0);
        check_val("rst_sop_eop_empty", {msg_if.startofpacket, msg_if.endofpacket, msg_if.empty}, 0);
        check_val("rst_data", msg_if.data, 0);
        check_val("rst_busy_done", {busy, done}, 0);
        check_val("rst_msg_cnt", msg_cnt, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // single message, ready always high
        start_run(16'd1, 1'b0);
        wait_done("t1_done", 200);
        check_val("t1_first_beat", run_first_data, 64'h0000001c24174acb);
        check_val("t1_last_beat", run_last_data, EXP_LAST0);
        check_val("t1_last_empty", run_last_empty, 4);
        check_val("t1_msgs", msgs_in_run, 1);
        @(negedge clk);
        #1;
        check_val("t1_busy_after", busy, 0);
        check_val("t1_cnt_hold", msg_cnt, 1);

        // three messages with idle gaps
        start_run(16'd3, 1'b0);
        wait_done("t2_done", 400);
        check_val("t2_msgs", msgs_in_run, 3);
        check_val("t2_cnt", msg_cnt, 3);

        // random backpressure
        rand_ready = 1'b1;
        start_run(16'd4, 1'b0);
        wait_done("t3_done", 3000);
        check_val("t3_msgs", msgs_in_run, 4);

        // start while busy must neither restart nor re-latch count
        start_run(16'd2, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        start = 1'b1;
        count = 16'd9;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done("t4_done", 3000);
        check_val("t4_msgs", msgs_in_run, 2);
        check_val("t4_cnt", msg_cnt, 2);
`ifdef MSG_GENERATOR_SEQ_EN
        check_val("t4_seq_last", run_last_data, 64'h0008000100000000);
`endif

        // start and stop together: exactly one message
        start_run(16'd0, 1'b1);
        wait_done("t5_done", 3000);
        check_val("t5_msgs", msgs_in_run, 1);

        // continuous run stopped during beat 2 of message 5
        start_run(16'd0, 1'b0);
        wait_pos("t6_reach", 5, 2, 6000);
        check_val("t6_cnt_at_stop", msg_cnt, 5);
        pulse_stop();
        wait_done("t6_done", 3000);
        check_val("t6_msgs", msgs_in_run, 6);
        vc = valid_cycles;
        repeat (30) @(negedge clk);
        #1;
        check_val("t6_quiet", valid_cycles - vc, 0);

        // reset in the middle of a message
        rand_ready = 1'b0;
        start_run(16'd0, 1'b0);
        wait_pos("t7_reach", 0, 3, 100);
        rst_n = 1'b0;
        #1;
        check_val("t7_rst_valid", msg_if.valid, 0);
        check_val("t7_rst_busy", busy, 0);
        check_val("t7_rst_eop", msg_if.endofpacket, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        start_run(16'd1, 1'b0);
        wait_done("t8_done", 200);
        check_val("t8_msgs", msgs_in_run, 1);
        check_val("t8_cnt", msg_cnt, 1);
        check_val("t8_first_beat", run_first_data, 64'h0000001c24174acb);

        check_val("sb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/msg_generator.md
Name: msg_generator

Overview:
- Avalon-ST message transmitter: replays a fixed, parameter-defined message on an avalon_st_if source port.
- Sends a programmed number of copies, or runs continuously, with a configurable idle gap between messages.
- Acts as the traffic source feeding msg_dropper-style sinks, in benches and on-chip self-test paths.
- Fully honours sink backpressure; never truncates a message.

Parameters:
- MSG_BYTES, 44, message length in bytes; must be at least 1.
- MSG_DATA, 'h0000001c24174acb00e04c68004108004500001c4bfd000080110000a9fe96dfa9fe0101c17507d00008ebf6, message content, MSG_BYTES*8 bits; MSB byte is sent first.
- GAP_CYCLES, 4, idle cycles (valid low) between eop acceptance and the next sop; 0 means back-to-back.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run when idle
- stop  in  1  pulse; ends the run after the current message
- count  in  16  messages per run, latched on start; 0 means continuous
- msg_out  avalon_st_if source  -  fields data[63:0], valid, ready, startofpacket, endofpacket, empty[2:0]
- busy  out  1  high while a run is active
- msg_cnt  out  16  messages fully accepted in the current run
- done  out  1  one-cycle pulse when a run ends

Behaviour:
- Reset (async assert, sync deassert use): valid=0, sop=0, eop=0, empty=0, data=0, busy=0, msg_cnt=0, done=0; FSM goes to IDLE.
- Reset asserted mid-message: the message is abandoned with no eop.
- Beat packing:
  - 8 bytes per beat, big-endian: message byte 0 on data[63:56].
  - Beats per message = ceil(MSG_BYTES/8).
  - Last beat: empty = 8*beats - MSG_BYTES; unused low bytes are driven 0.
  - A single-beat message has sop and eop high together.
- Handshake:
  - A beat transfers when valid && ready.
  - Once valid is high, data/sop/eop/empty stay stable and valid stays high until accepted.
  - valid never depends combinationally on ready.
- FSM:
  - IDLE: start -> SEND, latch count, clear msg_cnt, busy=1. start and stop on the same cycle -> exactly one message, then IDLE.
  - SEND: valid=1 and the beat index advances on each accept. On eop accept, msg_cnt increments, then:
    - stop_pending set, or (count != 0 and msg_cnt+1 == count) -> DONE;
    - else GAP_CYCLES > 0 -> GAP;
    - else stay in SEND with the next beat being sop (back-to-back).
  - GAP: valid=0; counts GAP_CYCLES cycles, then SEND. stop during GAP -> DONE immediately.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency:
  - start sampled at cycle N -> first valid/sop at cycle N+1.
  - First sop after an eop accepted at cycle M appears at cycle M+1+GAP_CYCLES.
- stop: latched into stop_pending while busy and cleared on DONE. The message in flight always completes.
- start while busy: ignored; count is not re-latched.
- msg_cnt: saturates at 0xFFFF in continuous mode and holds its value after DONE until the next start.
- Counters: the beat index and gap counter are sized with $clog2 and do not wrap inside a message.

Optional Feature:
- Macro: MSG_GENERATOR_SEQ_EN.
- Defined: the last two message bytes (offsets MSG_BYTES-2 and MSG_BYTES-1) are replaced by msg_cnt, big-endian, for the message being sent; this requires MSG_BYTES >= 2.
  - With defaults, message 0 ends 0x00080000 and message 1 ends 0x00080001.
- Undefined: MSG_DATA is sent unmodified.

Test Plan:
- Default params, ready=1, start with count=1 -> 6 beats. Beat 0 data=0x0000001c24174acb with sop=1. Beat 5 data=0x0008ebf600000000, eop=1, empty=4. Then done pulse, msg_cnt=1, busy=0.
- count=3, GAP_CYCLES=4, ready=1 -> three messages, each with exactly 4 valid-low cycles between eop and the next sop. msg_cnt sequence 1,2,3; done one cycle after the third eop.
- ready driven randomly 50% -> data/sop/eop held stable across stalls; byte stream identical to MSG_DATA; no duplicate or missing beats.
- count=0, stop asserted during beat 2 of message 5 -> message 5 completes with eop; msg_cnt=5 at stop and 6 at done; no further sop.
- rst_n pulsed low at beat 3 -> valid=0 and busy=0 immediately, with no eop; a new start then sends a clean message beginning with sop.
- MSG_GENERATOR_SEQ_EN defined, count=2 -> last beats are 0x0008000000000000 and 0x0008000100000000.
